brg_cgra_xcel_host_driver: RTL and testbench

//  Master-side driver that programs and monitors the CGRA accelerator over the manycore mesh.

---
 rtl/brg_cgra_xcel_pkg.sv | 52 +++++
 rtl/brg_cgra_xcel_host_driver.sv | 203 ++++++++++++++++++++
 tb/tb_brg_cgra_xcel_host_driver.sv | 385 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/brg_cgra_xcel_pkg.sv
// Shared types for the CGRA accelerator host driver and xcel wrapper:
// command ops, driver FSM states, mesh packet enums, accelerator CSR map.
package brg_cgra_xcel_pkg;

  typedef enum logic [1:0] {
    e_cmd_store = 2'd0,
    e_cmd_load  = 2'd1,
    e_cmd_poll  = 2'd2,
    e_cmd_fence = 2'd3
  } cmd_op_e;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SEND     = 3'd1,
    S_WAIT_RET = 3'd2,
    S_RESP     = 3'd3,
    S_GAP      = 3'd4,
    S_FENCE    = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    e_remote_load  = 2'd0,
    e_remote_store = 2'd1,
    e_remote_amo   = 2'd2,
    e_cache_op     = 2'd3
  } pkt_op_e;

  typedef enum logic [2:0] {
    e_return_credit   = 3'd0,
    e_return_int_wb   = 3'd1,
    e_return_float_wb = 3'd2,
    e_return_ifetch   = 3'd3
  } ret_type_e;

  localparam int unsigned RegIdW = 5;
  localparam int unsigned MaskW  = 4;

  localparam int unsigned XcelCsrGo      = 0;
  localparam int unsigned XcelCsrDone    = 1;
  localparam int unsigned XcelCsrCfgBase = 16;

  function automatic int unsigned pkt_width(
    input int unsigned aw,
    input int unsigned dw,
    input int unsigned xw,
    input int unsigned yw
  );
    return aw + $bits(pkt_op_e) + RegIdW
         + MaskW + dw + 2*xw + 2*yw;
  endfunction

endpackage

// File: rtl/brg_cgra_xcel_host_driver.sv
// Master-side driver: turns STORE/LOAD/POLL/FENCE commands into mesh
// packets, collects load replies, returns LOAD/POLL results.
module brg_cgra_xcel_host_driver
  import brg_cgra_xcel_pkg::*;
#(
  parameter int x_cord_width_p    = 6,
  parameter int y_cord_width_p    = 5,
  parameter int data_width_p      = 32,
  parameter int addr_width_p      = 16,
  parameter int max_out_credits_p = 32,
  parameter int poll_gap_p        = 16,
  localparam int CredW =
    $clog2(max_out_credits_p+1),
  localparam int PktW = pkt_width(
    addr_width_p, data_width_p,
    x_cord_width_p, y_cord_width_p)
)(
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic [x_cord_width_p-1:0] my_x_i,
  input  logic [y_cord_width_p-1:0] my_y_i,
  input  logic                      cmd_v_i,
  input  logic [1:0]                cmd_op_i,
  input  logic [x_cord_width_p-1:0] cmd_dest_x_i,
  input  logic [y_cord_width_p-1:0] cmd_dest_y_i,
  input  logic [addr_width_p-1:0]   cmd_addr_i,
  input  logic [data_width_p-1:0]   cmd_data_i,
  output logic                      cmd_ready_o,
  output logic                      resp_v_o,
  input  logic                      resp_yumi_i,
  output logic [data_width_p-1:0]   resp_data_o,
  output logic                      out_v_o,
  output logic [PktW-1:0]           out_packet_o,
  input  logic                      out_credit_or_ready_i,
  input  logic [CredW-1:0]          out_credits_i,
  input  logic [data_width_p-1:0]   returned_data_r_i,
  input  logic [RegIdW-1:0]         returned_reg_id_r_i,
  input  logic                      returned_v_r_i,
  input  ret_type_e                 returned_pkt_type_r_i,
  input  logic                      returned_fifo_full_i,
  output logic                      returned_yumi_o,
  output logic                      busy_o,
  output logic                      err_o
);

  localparam int GapW =
    (poll_gap_p > 1) ? $clog2(poll_gap_p) : 1;

  typedef struct packed {
    logic [addr_width_p-1:0]   addr;
    pkt_op_e                   op_v2;
    logic [RegIdW-1:0]         reg_id;
    logic [MaskW-1:0]          mask;
    logic [data_width_p-1:0]   payload;
    logic [y_cord_width_p-1:0] src_y_cord;
    logic [x_cord_width_p-1:0] src_x_cord;
    logic [y_cord_width_p-1:0] y_cord;
    logic [x_cord_width_p-1:0] x_cord;
  } pkt_s;

  state_e                    state_q, state_d;
  cmd_op_e                   op_q, op_d;
  logic [x_cord_width_p-1:0] dx_q, dx_d;
  logic [y_cord_width_p-1:0] dy_q, dy_d;
  logic [addr_width_p-1:0]   addr_q, addr_d;
  logic [data_width_p-1:0]   data_q, data_d;
  logic [data_width_p-1:0]   resp_q, resp_d;
  logic [RegIdW-1:0]         tag_q, tag_d;
  logic [GapW-1:0]           gap_q, gap_d;
  logic                      err_q, err_d;

  logic ret_bad;
  logic unused_fifo_full;
  pkt_s pkt;

  assign unused_fifo_full = returned_fifo_full_i;

  assign ret_bad =
    (returned_reg_id_r_i != tag_q) ||
    (returned_pkt_type_r_i != e_return_int_wb);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      op_q    <= e_cmd_store;
      dx_q    <= '0;
      dy_q    <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      resp_q  <= '0;
      tag_q   <= '0;
      gap_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      resp_q  <= resp_d;
      tag_q   <= tag_d;
      gap_q   <= gap_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    dx_d        = dx_q;
    dy_d        = dy_q;
    addr_d      = addr_q;
    data_d      = data_q;
    resp_d      = resp_q;
    tag_d       = tag_q;
    gap_d       = gap_q;
    err_d       = err_q;
    cmd_ready_o = 1'b0;
    out_v_o     = 1'b0;
    resp_v_o    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cmd_ready_o = 1'b1;
        if (cmd_v_i) begin
          op_d    = cmd_op_e'(cmd_op_i);
          dx_d    = cmd_dest_x_i;
          dy_d    = cmd_dest_y_i;
          addr_d  = cmd_addr_i;
          data_d  = cmd_data_i;
          state_d = (cmd_op_e'(cmd_op_i) == e_cmd_fence)
                  ? S_FENCE : S_SEND;
        end
      end
      S_SEND: begin
        // never present a packet the endpoint cannot take
        out_v_o = out_credit_or_ready_i;
        if (out_credit_or_ready_i) begin
          state_d = (op_q == e_cmd_store)
                  ? S_IDLE : S_WAIT_RET;
        end
      end
      S_WAIT_RET: begin
        if (returned_v_r_i) begin
          resp_d = returned_data_r_i;
          tag_d  = tag_q + RegIdW'(1);
          if (ret_bad) err_d = 1'b1;
          if (op_q == e_cmd_poll &&
              returned_data_r_i != data_q) begin
            gap_d   = '0;
            state_d = S_GAP;
          end else begin
            state_d = S_RESP;
          end
        end
      end
      S_GAP: begin
        if (gap_q == GapW'(poll_gap_p-1)) begin
          state_d = S_SEND;
        end else begin
          gap_d = gap_q + GapW'(1);
        end
      end
      S_RESP: begin
        resp_v_o = 1'b1;
        if (resp_yumi_i) state_d = S_IDLE;
      end
      S_FENCE: begin
        // full pool means every earlier store has been acked
        if (out_credits_i == CredW'(max_out_credits_p))
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // a reply nobody asked for is consumed and flagged
    if (returned_v_r_i && state_q != S_WAIT_RET)
      err_d = 1'b1;
  end

  always_comb begin
    pkt            = '0;
    pkt.addr       = addr_q;
    pkt.reg_id     = tag_q;
    pkt.src_y_cord = my_y_i;
    pkt.src_x_cord = my_x_i;
    pkt.y_cord     = dy_q;
    pkt.x_cord     = dx_q;
    if (op_q == e_cmd_store) begin
      pkt.op_v2   = e_remote_store;
      pkt.mask    = 4'hF;
      pkt.payload = data_q;
    end else begin
      pkt.op_v2   = e_remote_load;
    end
  end

  assign out_packet_o    = pkt;
  assign returned_yumi_o = returned_v_r_i & ~reset_i;
  assign resp_data_o     = resp_q;
  assign busy_o          = (state_q != S_IDLE);
  assign err_o           = err_q;

endmodule

// File: tb/tb_brg_cgra_xcel_host_driver.sv
// Scoreboard bench for brg_cgra_xcel_host_driver: directed commands,
// expected packets/responses queued, checked by a negedge monitor.
module tb_brg_cgra_xcel_host_driver;
  import brg_cgra_xcel_pkg::*;

  localparam int XW  = 6;
  localparam int YW  = 5;
  localparam int DW  = 32;
  localparam int AW  = 16;
  localparam int MC  = 32;
  localparam int GAP = 16;
  localparam int CW  = $clog2(MC+1);
  localparam logic [XW-1:0] MYX = 6'd3;
  localparam logic [YW-1:0] MYY = 5'd1;

  typedef struct packed {
    logic [AW-1:0]     addr;
    pkt_op_e           op_v2;
    logic [RegIdW-1:0] reg_id;
    logic [MaskW-1:0]  mask;
    logic [DW-1:0]     payload;
    logic [YW-1:0]     src_y_cord;
    logic [XW-1:0]     src_x_cord;
    logic [YW-1:0]     y_cord;
    logic [XW-1:0]     x_cord;
  } pkt_s;
  localparam int PW = $bits(pkt_s);

  logic clk = 1'b0;
  logic reset;
  logic cmd_v, cmd_ready;
  logic [1:0] cmd_op;
  logic [XW-1:0] cmd_x;
  logic [YW-1:0] cmd_y;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_data;
  logic resp_v, resp_yumi;
  logic [DW-1:0] resp_data;
  logic out_v, out_rdy;
  logic [PW-1:0] out_pkt;
  logic [CW-1:0] credits;
  logic [DW-1:0] ret_data;
  logic [RegIdW-1:0] ret_id;
  logic ret_v, ret_full, ret_yumi;
  ret_type_e ret_type;
  logic busy, err;

  always #5 clk = ~clk;

  brg_cgra_xcel_host_driver #(
    .x_cord_width_p(XW), .y_cord_width_p(YW),
    .data_width_p(DW), .addr_width_p(AW),
    .max_out_credits_p(MC), .poll_gap_p(GAP)
  ) dut (
    .clk_i(clk), .reset_i(reset),
    .my_x_i(MYX), .my_y_i(MYY),
    .cmd_v_i(cmd_v), .cmd_op_i(cmd_op),
    .cmd_dest_x_i(cmd_x), .cmd_dest_y_i(cmd_y),
    .cmd_addr_i(cmd_addr), .cmd_data_i(cmd_data),
    .cmd_ready_o(cmd_ready),
    .resp_v_o(resp_v), .resp_yumi_i(resp_yumi),
    .resp_data_o(resp_data),
    .out_v_o(out_v), .out_packet_o(out_pkt),
    .out_credit_or_ready_i(out_rdy),
    .out_credits_i(credits),
    .returned_data_r_i(ret_data),
    .returned_reg_id_r_i(ret_id),
    .returned_v_r_i(ret_v),
    .returned_pkt_type_r_i(ret_type),
    .returned_fifo_full_i(ret_full),
    .returned_yumi_o(ret_yumi),
    .busy_o(busy), .err_o(err)
  );

  int vec = 0;
  int bad = 0;
  int cyc = 0;
  pkt_s exp_q[$];
  logic [DW-1:0] rexp_q[$];
  int pcyc[$];
  pkt_s opkt, epkt;

  assign opkt = pkt_s'(out_pkt);

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    vec++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  function automatic pkt_s mk(
    input logic [AW-1:0] a, input pkt_op_e op,
    input logic [4:0] id, input logic [DW-1:0] d);
    pkt_s p;
    p            = '0;
    p.addr       = a;
    p.op_v2      = op;
    p.reg_id     = id;
    p.mask       = (op == e_remote_store) ? 4'hF : 4'h0;
    p.payload    = (op == e_remote_store) ? d : '0;
    p.src_y_cord = MYY;
    p.src_x_cord = MYX;
    p.y_cord     = 5'd2;
    p.x_cord     = 6'd16;
    return p;
  endfunction

  // monitor: packets and responses against the scoreboard
  always @(negedge clk) begin
    if (reset) begin
      resp_yumi = 1'b0;
    end else begin
      if (out_v) chk("out_v_needs_ready", out_rdy, 1);
      if (out_v && out_rdy) begin
        pcyc.push_back(cyc);
        chk("pkt_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          epkt = exp_q.pop_front();
          chk("pkt_hdr",
              {opkt.addr, opkt.op_v2, opkt.reg_id, opkt.mask},
              {epkt.addr, epkt.op_v2, epkt.reg_id, epkt.mask});
          chk("pkt_payload", opkt.payload, epkt.payload);
          chk("pkt_cords",
              {opkt.src_y_cord, opkt.src_x_cord,
               opkt.y_cord, opkt.x_cord},
              {epkt.src_y_cord, epkt.src_x_cord,
               epkt.y_cord, epkt.x_cord});
        end
      end
      if (resp_v && !resp_yumi) begin
        chk("resp_expected", rexp_q.size() > 0, 1);
        if (rexp_q.size() > 0)
          chk("resp_data", resp_data, rexp_q.pop_front());
        resp_yumi = 1'b1;
      end else begin
        resp_yumi = 1'b0;
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue(input cmd_op_e op,
                       input logic [AW-1:0] a,
                       input logic [DW-1:0] d,
                       output int acc);
    int b;
    b = 0;
    while (!cmd_ready && b < 200) begin
      step();
      b++;
    end
    chk("cmd_ready_wait", cmd_ready, 1);
    cmd_v    = 1'b1;
    cmd_op   = op;
    cmd_x    = 6'd16;
    cmd_y    = 5'd2;
    cmd_addr = a;
    cmd_data = d;
    step();
    acc   = cyc;
    cmd_v = 1'b0;
  endtask

  task automatic wait_pkts(input int n);
    int b;
    b = 0;
    while (pcyc.size() < n && b < 300) begin
      step();
      b++;
    end
    chk("pkt_arrived", pcyc.size() >= n, 1);
  endtask

  task automatic reply(input logic [DW-1:0] d,
                       input logic [4:0] id,
                       input ret_type_e t);
    ret_v    = 1'b1;
    ret_data = d;
    ret_id   = id;
    ret_type = t;
    @(negedge clk);
    chk("ret_yumi", ret_yumi, 1);
    @(posedge clk);
    #1;
    ret_v = 1'b0;
  endtask

  task automatic wait_idle();
    int b;
    b = 0;
    while ((busy || rexp_q.size() > 0) && b < 300) begin
      step();
      b++;
    end
    chk("idle_reached", busy, 0);
    chk("resp_drained", rexp_q.size(), 0);
  endtask

  task automatic chk_rst();
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_out_v", out_v, 0);
    chk("rst_resp_v", resp_v, 0);
    chk("rst_ret_yumi", ret_yumi, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
  endtask

  initial begin
    int acc, r;
    reset    = 1'b1;
    cmd_v    = 1'b0;
    cmd_op   = '0;
    cmd_x    = '0;
    cmd_y    = '0;
    cmd_addr = '0;
    cmd_data = '0;
    out_rdy  = 1'b1;
    credits  = CW'(MC);
    ret_v    = 1'b0;
    ret_data = '0;
    ret_id   = '0;
    ret_type = e_return_int_wb;
    ret_full = 1'b0;
    resp_yumi = 1'b0;
    step(3);
    reset = 1'b0;
    @(negedge clk);
    chk_rst();
    step();

    // STORE: one packet in the cycle after accept
    pcyc.delete();
    exp_q.push_back(mk(16'h100, e_remote_store,
                       5'd0, 32'hDEADBEEF));
    issue(e_cmd_store, 16'h100, 32'hDEADBEEF, acc);
    wait_pkts(1);
    chk("store_latency", pcyc[0], acc);
    step(3);
    chk("store_pkt_count", pcyc.size(), 1);
    chk("store_back_idle", cmd_ready, 1);

    // LOAD with reply after 7 cycles
    pcyc.delete();
    exp_q.push_back(mk(16'h104, e_remote_load, 5'd0, '0));
    rexp_q.push_back(32'h12345678);
    issue(e_cmd_load, 16'h104, '0, acc);
    wait_pkts(1);
    step(7);
    reply(32'h12345678, 5'd0, e_return_int_wb);
    wait_idle();
    chk("load_err", err, 0);

    // POLL until value 1: tags 1,2,3
    pcyc.delete();
    for (int i = 0; i < 3; i++)
      exp_q.push_back(mk(16'h108, e_remote_load,
                         5'(1 + i), '0));
    rexp_q.push_back(32'd1);
    issue(e_cmd_poll, 16'h108, 32'd1, acc);
    for (int i = 0; i < 3; i++) begin
      wait_pkts(i + 1);
      step(2);
      reply((i == 2) ? 32'd1 : 32'd0,
            5'(1 + i), e_return_int_wb);
    end
    wait_idle();
    step(GAP + 4);
    chk("poll_pkt_count", pcyc.size(), 3);
    for (int i = 1; i < pcyc.size(); i++)
      chk("poll_spacing",
          (pcyc[i] - pcyc[i-1]) >= GAP + 1, 1);
    chk("poll_err", err, 0);

    // endpoint not ready for 10 cycles during SEND
    pcyc.delete();
    out_rdy = 1'b0;
    exp_q.push_back(mk(16'h10C, e_remote_store,
                       5'd4, 32'hCAFEF00D));
    issue(e_cmd_store, 16'h10C, 32'hCAFEF00D, acc);
    step(10);
    chk("stall_out_v", out_v, 0);
    chk("stall_no_pkt", pcyc.size(), 0);
    chk("stall_busy", busy, 1);
    out_rdy = 1'b1;
    r = cyc;
    wait_pkts(1);
    chk("stall_release", pcyc[0], r);
    step(2);

    // 4 stores drain credits to 28, FENCE waits for 32
    pcyc.delete();
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(mk(16'(16'h200 + 4*k),
                         e_remote_store, 5'd4, 32'(k)));
      issue(e_cmd_store, 16'(16'h200 + 4*k),
            32'(k), acc);
      wait_pkts(k + 1);
      credits = CW'(MC - 1 - k);
    end
    issue(e_cmd_fence, '0, '0, acc);
    for (int t = 1; t <= 20; t++) begin
      step();
      chk("fence_hold", cmd_ready, 0);
      if (t % 5 == 0) credits = credits + CW'(1);
    end
    chk("fence_credits_full", credits, MC);
    @(negedge clk);
    chk("fence_same_cycle", cmd_ready, 0);
    step();
    chk("fence_release", cmd_ready, 1);
    chk("fence_no_pkt", pcyc.size(), 4);

    // tag mismatch sets sticky err
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    @(negedge clk);
    chk_rst();
    step();
    pcyc.delete();
    exp_q.push_back(mk(16'h110, e_remote_load, 5'd0, '0));
    rexp_q.push_back(32'hA5A5A5A5);
    issue(e_cmd_load, 16'h110, '0, acc);
    wait_pkts(1);
    step(2);
    reply(32'hA5A5A5A5, 5'd5, e_return_int_wb);
    wait_idle();
    chk("tag_mismatch_err", err, 1);
    step(5);
    chk("err_sticky", err, 1);

    // reset while waiting for a reply
    pcyc.delete();
    exp_q.push_back(mk(16'h114, e_remote_load, 5'd1, '0));
    issue(e_cmd_load, 16'h114, '0, acc);
    wait_pkts(1);
    step(2);
    chk("wait_ret_busy", busy, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    chk_rst();
    step();

    // wrong return type sets err
    pcyc.delete();
    exp_q.push_back(mk(16'h118, e_remote_load, 5'd0, '0));
    rexp_q.push_back(32'h55);
    issue(e_cmd_load, 16'h118, '0, acc);
    wait_pkts(1);
    step(1);
    reply(32'h55, 5'd0, e_return_credit);
    wait_idle();
    chk("type_mismatch_err", err, 1);

    // stray reply while IDLE
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    chk("err_cleared", err, 0);
    reply(32'h1, 5'd0, e_return_int_wb);
    step();
    chk("stray_reply_err", err, 1);
    chk("stray_idle", busy, 0);

    chk("exp_q_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vec, bad);
    $finish;
  end

endmodule
